uart_result_framer: RTL and testbench

Controller that sequences readout of convolution results from the result BRAM and schedules them onto the shared UART transmitter as a framed byte stream. Sits between the convolution engine (its `done` pulse starts a frame), the result BRAM read port, and `uart_transmission` (drives `send`/`data_in`, observes `busy`). Each frame carries a header, every result word as three sign-extended bytes, and an XOR checksum, so the host can resynchronise and validate.

---
 rtl/uart_result_framer.sv | 198 +++++++++++++++++++
 tb/tb_uart_result_framer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_framer.sv
// uart_result_framer
//   Reads convolution results out of the result BRAM and streams them to the
//   shared UART transmitter as one framed packet per engine 'done':
//     A5, N[15:8], N[7:0], {3 sign-extended bytes per word}, XOR checksum
//   The checksum covers payload bytes only.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   start       one-cycle pulse from the engine; only honoured in IDLE
//   rd_addr     registered BRAM read address
//   rd_data     BRAM read data, valid one cycle after rd_addr
//   tx_busy     transmitter busy
//   tx_send     one-cycle transmit request
//   tx_data     byte to transmit, held from its SEND until the next SEND
//   frame_busy  high while a frame is in progress
//   frame_done  one-cycle pulse when the frame completes
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start
// HDR     | sending the three header bytes
// FETCH   | rd_addr holds the word index, BRAM read in flight
// LATCH   | rd_data valid; capture it, sign-extended to 24 bits
// DATA    | sending the three bytes of the captured word
// CSUM    | sending the checksum byte
// DONE    | frame_done pulse, back to IDLE
//
// phase   | meaning (HDR/DATA/CSUM only)
// --------+--------------------------------------------------------------
// SEND    | tx_send is high this cycle
// GUARD   | transmitter has not raised busy yet; tx_busy is ignored
// WAIT    | wait for tx_busy low, then send next byte or change state
module uart_result_framer #(
  parameter int N_RESULTS = 676,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              tx_busy,
  output logic              tx_send,
  output logic [7:0]        tx_data,
  output logic              frame_busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_FETCH, S_LATCH, S_DATA, S_CSUM, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    P_SEND, P_GUARD, P_WAIT
  } phase_t;

  localparam logic [15:0] N_LAST = 16'(N_RESULTS - 1);
  localparam logic [7:0]  N_HI   = 8'((N_RESULTS >> 8) & 255);
  localparam logic [7:0]  N_LO   = 8'(N_RESULTS & 255);

  state_t      state;
  phase_t      phase;
  logic [1:0]  sel;      // bytes already sent in the current state
  logic [15:0] idx;
  logic [23:0] word_q;
  logic [7:0]  csum;

  logic [23:0] rd_ext;
  logic [7:0]  hdr_byte;
  logic [7:0]  data_byte;

  assign rd_ext = 24'($signed(rd_data));

  always_comb begin
    hdr_byte = 8'hA5;
    case (sel)
      2'd1:    hdr_byte = N_HI;
      2'd2:    hdr_byte = N_LO;
      default: hdr_byte = 8'hA5;
    endcase
  end

  always_comb begin
    data_byte = word_q[23:16];
    case (sel)
      2'd1:    data_byte = word_q[15:8];
      2'd2:    data_byte = word_q[7:0];
      default: data_byte = word_q[23:16];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      phase      <= P_WAIT;
      sel        <= 2'd0;
      idx        <= 16'd0;
      word_q     <= 24'd0;
      csum       <= 8'd0;
      rd_addr    <= '0;
      tx_send    <= 1'b0;
      tx_data    <= 8'h00;
      frame_busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tx_send    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            frame_busy <= 1'b1;
            idx        <= 16'd0;
            csum       <= 8'd0;
            state      <= S_HDR;
            // Send the sync byte straight away when the UART is free.
            if (!tx_busy) begin
              tx_send <= 1'b1;
              tx_data <= 8'hA5;
              sel     <= 2'd1;
              phase   <= P_SEND;
            end else begin
              sel     <= 2'd0;
              phase   <= P_WAIT;
            end
          end
        end

        S_FETCH: state <= S_LATCH;

        S_LATCH: begin
          word_q <= rd_ext;
          state  <= S_DATA;
          // First payload byte goes out directly from the BRAM data.
          if (!tx_busy) begin
            tx_send <= 1'b1;
            tx_data <= rd_ext[23:16];
            csum    <= csum ^ rd_ext[23:16];
            sel     <= 2'd1;
            phase   <= P_SEND;
          end else begin
            sel     <= 2'd0;
            phase   <= P_WAIT;
          end
        end

        S_DONE: state <= S_IDLE;

        default: begin
          case (phase)
            P_SEND:  phase <= P_GUARD;
            P_GUARD: phase <= P_WAIT;
            default: begin
              if (!tx_busy) begin
                if (state == S_HDR) begin
                  if (sel != 2'd3) begin
                    tx_send <= 1'b1;
                    tx_data <= hdr_byte;
                    sel     <= sel + 2'd1;
                    phase   <= P_SEND;
                  end else begin
                    rd_addr <= ADDR_W'(idx);
                    state   <= S_FETCH;
                  end
                end else if (state == S_DATA) begin
                  if (sel != 2'd3) begin
                    tx_send <= 1'b1;
                    tx_data <= data_byte;
                    csum    <= csum ^ data_byte;
                    sel     <= sel + 2'd1;
                    phase   <= P_SEND;
                  end else if (idx != N_LAST) begin
                    idx     <= idx + 16'd1;
                    rd_addr <= ADDR_W'(idx + 16'd1);
                    state   <= S_FETCH;
                  end else begin
                    // csum already includes every payload byte sent so far.
                    state   <= S_CSUM;
                    tx_send <= 1'b1;
                    tx_data <= csum;
                    sel     <= 2'd1;
                    phase   <= P_SEND;
                  end
                end else begin
                  state      <= S_DONE;
                  frame_done <= 1'b1;
                  frame_busy <= 1'b0;
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_result_framer.sv
module tb_uart_result_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] rd_addr;
  logic [22:0] rd_data;
  logic        tx_busy;
  logic        tx_send;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        frame_done;

  uart_result_framer #(.N_RESULTS(2), .ADDR_W(16), .DATA_W(23)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .tx_busy(tx_busy), .tx_send(tx_send), .tx_data(tx_data),
    .frame_busy(frame_busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: one-cycle read latency
  logic [22:0] mem [0:3];
  always @(posedge clk) rd_data <= mem[rd_addr[1:0]];

  // UART model: busy for busy_len cycles starting the cycle after send
  int   busy_len_v = 0;
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;
  always @(posedge clk) begin
    if (tx_send === 1'b1) busy_cnt <= busy_len_v;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = force_busy | (busy_cnt != 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard
  logic [7:0] exp_q[$];
  int         send_cyc_q[$];
  int         frame_bytes = 0;
  int         n_done = 0;
  int         prev_send = -100;
  logic [7:0] last_byte = 8'h00;

  always @(negedge clk) begin
    if (tx_send === 1'b1) begin
      check("send_while_busy", {31'd0, tx_busy}, 0);
      check("frame_busy_at_send", {31'd0, frame_busy}, 1);
      check("send_gap_min", {31'd0, (cyc - prev_send) >= 3}, 1);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_send: got %0h expected no byte", tx_data);
      end else begin
        check("tx_byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      prev_send = cyc;
      last_byte = tx_data;
      frame_bytes++;
      send_cyc_q.push_back(cyc);
    end
    if (frame_done === 1'b1) n_done++;
  end

  task automatic build_exp(input logic [22:0] w0, input logic [22:0] w1);
    logic [23:0] v;
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [22:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h02);
    cs = 8'h00;
    for (int i = 0; i < 2; i++) begin
      w = (i == 0) ? w0 : w1;
      v = {w[22], w};
      for (int k = 0; k < 3; k++) begin
        b = v[23 - 8*k -: 8];
        exp_q.push_back(b);
        cs = cs ^ b;
      end
    end
    exp_q.push_back(cs);
  endtask

  typedef struct {
    logic [22:0] w0;
    logic [22:0] w1;
    int          busy_len;
    logic [7:0]  csum;
    int          pre_busy;
    bit          mid_start;
    bit          done_start;
    bit          chk_gaps;
  } vec_t;

  vec_t vecs[5];
  int   gaps_exp[9];

  task automatic run_frame(input vec_t v, input int reset_at);
    int  done0;
    bit  done_seen;
    bit  pulsed;
    bit  reset_hit;
    mem[0] = v.w0;
    mem[1] = v.w1;
    busy_len_v = v.busy_len;
    build_exp(v.w0, v.w1);
    frame_bytes = 0;
    send_cyc_q.delete();
    done0 = n_done;
    done_seen = 0;
    pulsed = 0;
    reset_hit = 0;

    @(negedge clk); #1;
    if (v.pre_busy > 0) force_busy = 1'b1;
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    check("frame_busy_rise", {31'd0, frame_busy}, 1);
    check("first_send", {31'd0, tx_send}, {31'd0, v.pre_busy == 0});
    if (v.pre_busy > 0) begin
      repeat (v.pre_busy) @(negedge clk);
      #1;
      check("gated_no_send", frame_bytes, 0);
      force_busy = 1'b0;
    end

    for (int t = 0; t < 20000; t++) begin
      @(negedge clk); #1;
      start = 1'b0;
      if (v.mid_start && !pulsed && frame_bytes >= 5) begin
        start = 1'b1;
        pulsed = 1;
      end
      if (reset_at != 0 && frame_bytes >= reset_at) begin
        reset_hit = 1;
        break;
      end
      if (frame_done === 1'b1) begin
        done_seen = 1;
        if (v.done_start) start = 1'b1;
        break;
      end
    end

    if (reset_at != 0) begin
      check("reset_reached", {31'd0, reset_hit}, 1);
      reset = 1'b1;
      @(negedge clk); #1;
      reset = 1'b0;
      check("mid_rst_tx_send", {31'd0, tx_send}, 0);
      check("mid_rst_frame_busy", {31'd0, frame_busy}, 0);
      check("mid_rst_frame_done", {31'd0, frame_done}, 0);
      repeat (30) @(negedge clk);
      #1;
      check("mid_rst_no_done", n_done - done0, 0);
      check("mid_rst_no_more_bytes", frame_bytes, reset_at);
      exp_q.delete();
    end else begin
      check("frame_done_seen", {31'd0, done_seen}, 1);
      check("frame_busy_drop", {31'd0, frame_busy}, 0);
      check("byte_count", frame_bytes, 10);
      check("csum", {24'd0, last_byte}, {24'd0, v.csum});
      check("exp_q_empty", exp_q.size(), 0);
      if (v.chk_gaps && send_cyc_q.size() == 10) begin
        for (int i = 0; i < 9; i++)
          check("send_gap", send_cyc_q[i+1] - send_cyc_q[i], gaps_exp[i]);
      end
      @(negedge clk); #1;
      start = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("single_done", n_done - done0, 1);
      check("no_restart", frame_bytes, 10);
      check("idle_after_done", {31'd0, frame_busy}, 0);
    end
  endtask

  initial begin
    vec_t rv;
    mem[0] = 23'd0; mem[1] = 23'd0; mem[2] = 23'd0; mem[3] = 23'd0;
    vecs[0] = '{23'h000001, 23'h7FFFFF, 10,   8'hFE, 0,   1'b0, 1'b0, 1'b0};
    vecs[1] = '{23'h3FFFFF, 23'h400000, 3,    8'hFF, 0,   1'b0, 1'b0, 1'b0};
    vecs[2] = '{23'h123456, 23'h654321, 0,    8'hF7, 0,   1'b0, 1'b0, 1'b1};
    vecs[3] = '{23'h000000, 23'h000000, 1,    8'h00, 0,   1'b1, 1'b1, 1'b0};
    vecs[4] = '{23'h000001, 23'h7FFFFF, 1000, 8'hFE, 200, 1'b0, 1'b0, 1'b0};
    gaps_exp = '{3, 3, 5, 3, 3, 5, 3, 3, 3};

    reset = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      start = 1'($urandom_range(0, 1));
      force_busy = 1'($urandom_range(0, 1));
      mem[0] = 23'($urandom);
      @(negedge clk);
      check("rst_no_send", {31'd0, tx_send}, 0);
    end
    #1;
    check("rst_rd_addr", {16'd0, rd_addr}, 0);
    check("rst_tx_send", {31'd0, tx_send}, 0);
    check("rst_tx_data", {24'd0, tx_data}, 0);
    check("rst_frame_busy", {31'd0, frame_busy}, 0);
    check("rst_frame_done", {31'd0, frame_done}, 0);
    start = 1'b0;
    force_busy = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], 0);

    // Reset after the 5th byte, then a fresh frame must start from A5.
    run_frame(vecs[0], 5);
    rv = '{23'h000ABC, 23'h7FFF00, 10, 8'hB6, 0, 1'b0, 1'b0, 1'b0};
    run_frame(rv, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
